// File: rtl/hazard_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_unit_pkg: shared encodings for the MIPS pipeline hazard unit   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package hazard_unit_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // M-stage result is younger than W, so it takes priority; $0 is hardwired zero.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] wr_m, input logic we_m,
                                         input logic [4:0] wr_w, input logic we_w);
    if (src != 5'd0 && we_m && src == wr_m) return FWD_M;
    if (src != 5'd0 && we_w && src == wr_w) return FWD_W;
    return FWD_RF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit_div_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_unit_div_seq: holds E-stage for an iterative DIV/DIVU          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module hazard_unit_div_seq
  import hazard_unit_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic div_e,
  output logic div_stall,
  output logic div_done,
  output logic div_busy
);

  localparam int CNT_BITS = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] C_LOAD = CNT_BITS'(DIV_CYCLES - 2);

  div_state_e          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  // BUSY lasts C_LOAD cycles, so trigger + BUSY + DONE spans exactly DIV_CYCLES.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DIV_IDLE: begin
        if (div_e) begin
          state_d = (C_LOAD == '0) ? DIV_DONE : DIV_BUSY;
          cnt_d   = C_LOAD;
        end
      end
      DIV_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_BITS'(1)) begin
          state_d = DIV_DONE;
          cnt_d   = '0;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign div_stall = (state_q == DIV_IDLE && div_e) || (state_q == DIV_BUSY);
  assign div_done  = (state_q == DIV_DONE);
  assign div_busy  = (state_q != DIV_IDLE);

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_unit: stall, flush and bypass control for the 5-stage MIPS     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic             branchD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic             regwriteE,
  input  logic             memtoregE,
  input  logic             divE,
  input  logic [4:0]       writeregM,
  input  logic             regwriteM,
  input  logic             memtoregM,
  input  logic [4:0]       writeregW,
  input  logic             regwriteW,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushE,
  output logic             flushM,
  output logic             forwardaD,
  output logic             forwardbD,
  output logic [1:0]       forwardaE,
  output logic [1:0]       forwardbE,
  output logic             divbusy,
  output logic             divdoneE,
  output logic [CNT_W-1:0] stallcnt
);

  logic w_lwstall, w_branchstall, w_divstall;
  logic w_e_hits_d, w_m_hits_d, w_stall_any;
  logic [CNT_W-1:0] stallcnt_q, stallcnt_d;

  assign forwardaE = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
  assign forwardbE = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
  assign forwardaD = (rsD != 5'd0) && regwriteM && (rsD == writeregM);
  assign forwardbD = (rtD != 5'd0) && regwriteM && (rtD == writeregM);

  assign w_e_hits_d = (writeregE != 5'd0) && (writeregE == rsD || writeregE == rtD);
  assign w_m_hits_d = (writeregM != 5'd0) && (writeregM == rsD || writeregM == rtD);

  assign w_lwstall     = memtoregE && w_e_hits_d;
  // Branches resolve in D, so an ALU result still in E or a load in M is too late.
  assign w_branchstall = branchD && ((regwriteE && w_e_hits_d) || (memtoregM && w_m_hits_d));

  hazard_unit_div_seq #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_seq (
    .clk      (clk),
    .rst      (rst),
    .div_e    (divE),
    .div_stall(w_divstall),
    .div_done (divdoneE),
    .div_busy (divbusy)
  );

  assign w_stall_any = w_lwstall || w_branchstall || w_divstall;
  assign stallF      = w_stall_any;
  assign stallD      = w_stall_any;
  assign stallE      = w_divstall;
  assign flushE      = (w_lwstall || w_branchstall) && !w_divstall;
  assign flushM      = w_divstall;

  always_comb begin
    stallcnt_d = stallcnt_q;
    if (w_stall_any && stallcnt_q != {CNT_W{1'b1}}) stallcnt_d = stallcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stallcnt_q <= '0;
    else      stallcnt_q <= stallcnt_d;
  end

  assign stallcnt = stallcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hazard_unit: directed scoreboard bench for hazard_unit             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_hazard_unit;

  localparam int C_DIV = 32;
  localparam int C_CW  = 4;

  logic clk, rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic branchD, regwriteE, memtoregE, divE, regwriteM, memtoregM, regwriteW;
  logic stallF, stallD, stallE, flushE, flushM, forwardaD, forwardbD;
  logic [1:0] forwardaE, forwardbE;
  logic divbusy, divdoneE;
  logic [C_CW-1:0] stallcnt;

  hazard_unit #(.DIV_CYCLES(C_DIV), .CNT_W(C_CW)) dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
    .memtoregE(memtoregE), .divE(divE), .writeregM(writeregM),
    .regwriteM(regwriteM), .memtoregM(memtoregM), .writeregW(writeregW),
    .regwriteW(regwriteW), .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushE(flushE), .flushM(flushM), .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE), .divbusy(divbusy),
    .divdoneE(divdoneE), .stallcnt(stallcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    logic sf, se, fe, fm, fad, fbd, busy, done;
    logic [1:0] fae, fbe;
    logic [C_CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  logic [C_CW-1:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0; writeregM = 0; writeregW = 0;
    branchD = 0; regwriteE = 0; memtoregE = 0; divE = 0;
    regwriteM = 0; memtoregM = 0; regwriteW = 0;
  endtask

  // Push the expectation, compare at the falling edge, then advance one clock.
  task automatic cycle(input string tag, input logic sf, input logic se, input logic fe,
                       input logic fm, input logic fad, input logic fbd,
                       input logic [1:0] fae, input logic [1:0] fbe,
                       input logic busy, input logic done);
    exp_t e;
    e.tag = tag; e.sf = sf; e.se = se; e.fe = fe; e.fm = fm; e.fad = fad; e.fbd = fbd;
    e.fae = fae; e.fbe = fbe; e.busy = busy; e.done = done; e.cnt = exp_cnt;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, ".stallF"}, 32'(stallF), 32'(e.sf));
    chk({e.tag, ".stallD"}, 32'(stallD), 32'(e.sf));
    chk({e.tag, ".stallE"}, 32'(stallE), 32'(e.se));
    chk({e.tag, ".flushE"}, 32'(flushE), 32'(e.fe));
    chk({e.tag, ".flushM"}, 32'(flushM), 32'(e.fm));
    chk({e.tag, ".forwardaD"}, 32'(forwardaD), 32'(e.fad));
    chk({e.tag, ".forwardbD"}, 32'(forwardbD), 32'(e.fbd));
    chk({e.tag, ".forwardaE"}, 32'(forwardaE), 32'(e.fae));
    chk({e.tag, ".forwardbE"}, 32'(forwardbE), 32'(e.fbe));
    chk({e.tag, ".divbusy"}, 32'(divbusy), 32'(e.busy));
    chk({e.tag, ".divdoneE"}, 32'(divdoneE), 32'(e.done));
    chk({e.tag, ".stallcnt"}, 32'(stallcnt), 32'(e.cnt));
    if (rst && e.sf && exp_cnt != {C_CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    #1;
    chk("reset.stallcnt", 32'(stallcnt), 0);
    chk("reset.divbusy", 32'(divbusy), 0);
    exp_cnt = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    cycle("por", 0,0,0,0,0,0, 2'b00,2'b00, 0,0);
    rst = 1'b1;

    // Forwarding priority and $0 exclusion
    rsE = 5; rtE = 5; rtD = 5; writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1;
    cycle("fwd_m", 0,0,0,0,0,1, 2'b10,2'b10, 0,0);
    regwriteM = 0;
    cycle("fwd_w", 0,0,0,0,0,0, 2'b01,2'b01, 0,0);
    rsE = 0;
    cycle("fwd_r0", 0,0,0,0,0,0, 2'b00,2'b01, 0,0);

    // Load-use: one bubble, then the load has moved to M
    clear_inputs();
    memtoregE = 1; regwriteE = 1; writeregE = 8; rtD = 8;
    cycle("lw_use", 1,0,1,0,0,0, 2'b00,2'b00, 0,0);
    clear_inputs();
    rtD = 8; writeregM = 8; memtoregM = 1; regwriteM = 1;
    cycle("lw_after", 0,0,0,0,0,1, 2'b00,2'b00, 0,0);

    // Branch after ALU op, then bypass from M
    clear_inputs();
    branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3;
    cycle("br_alu", 1,0,1,0,0,0, 2'b00,2'b00, 0,0);
    regwriteE = 0; writeregE = 0; writeregM = 3; regwriteM = 1;
    cycle("br_fwd", 0,0,0,0,1,0, 2'b00,2'b00, 0,0);
    clear_inputs();
    branchD = 1; rsD = 4; writeregM = 4; memtoregM = 1; regwriteM = 1;
    cycle("br_load_m", 1,0,1,0,1,0, 2'b00,2'b00, 0,0);
    clear_inputs();
    branchD = 1; regwriteE = 1; writeregE = 0;
    cycle("br_r0", 0,0,0,0,0,0, 2'b00,2'b00, 0,0);
    clear_inputs();
    memtoregE = 1; writeregE = 0;
    cycle("lw_r0", 0,0,0,0,0,0, 2'b00,2'b00, 0,0);

    // Divide with divE held: 31 stall cycles, one done cycle, then idle
    do_reset();
    for (int i = 0; i < C_DIV - 1; i++) begin
      clear_inputs();
      divE = 1;
      if (i == 5) begin memtoregE = 1; writeregE = 8; rtD = 8; end
      cycle($sformatf("div_%0d", i), 1,1,0,1,0,0, 2'b00,2'b00, (i > 0),0);
    end
    clear_inputs();
    divE = 1;
    cycle("div_done", 0,0,0,0,0,0, 2'b00,2'b00, 1,1);
    divE = 0;
    cycle("div_idle", 0,0,0,0,0,0, 2'b00,2'b00, 0,0);
    divE = 1;
    cycle("div_restart", 1,1,0,1,0,0, 2'b00,2'b00, 0,0);
    cycle("div_restart_busy", 1,1,0,1,0,0, 2'b00,2'b00, 1,0);

    // Reset in the middle of BUSY aborts with no done pulse
    do_reset();
    divE = 1;
    for (int i = 0; i <= 10; i++)
      cycle($sformatf("abort_%0d", i), 1,1,0,1,0,0, 2'b00,2'b00, (i > 0),0);
    rst = 1'b0;
    divE = 0;
    #1;
    chk("abort.divbusy", 32'(divbusy), 0);
    chk("abort.stallcnt", 32'(stallcnt), 0);
    chk("abort.divdoneE", 32'(divdoneE), 0);
    exp_cnt = '0;
    cycle("abort_hold", 0,0,0,0,0,0, 2'b00,2'b00, 0,0);
    rst = 1'b1;
    for (int i = 0; i < 35; i++)
      cycle($sformatf("abort_post_%0d", i), 0,0,0,0,0,0, 2'b00,2'b00, 0,0);

    // Stall counter saturation
    do_reset();
    memtoregE = 1; writeregE = 8; rsD = 8;
    for (int i = 0; i < 20; i++)
      cycle($sformatf("sat_%0d", i), 1,0,1,0,0,0, 2'b00,2'b00, 0,0);
    clear_inputs();
    cycle("sat_end", 0,0,0,0,0,0, 2'b00,2'b00, 0,0);
    chk("sat.stallcnt", 32'(stallcnt), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
